multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes opcode and funct, then sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath control strobe.
- Drives the 3-bit ALU operation class consumed by the ALU control decoder. This block is the encoder side of that interface.

---
 rtl/multicycle_control.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// strobe plus the 3-bit ALU operation class for the ALU control decoder.
// Optional feature: define MULTICYCLE_JAL_EN to enable the JAL path (state 12).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH  0  | read instruction at PC, load IR and PC+4 on mem_ready_i
// DECODE 1  | register read, branch target precompute, opcode dispatch
// MEM_ADDR 2| effective address = A + sign-extended imm
// MEM_READ 3| load data read from ALUOut address
// MEM_WB 4  | write MDR to rt
// MEM_WRITE5| store B to ALUOut address
// R_EXEC 6  | R-type ALU operation
// R_WB 7    | write ALUOut to rd
// BRANCH 8  | compare A/B, conditional PC load from ALUOut
// JUMP 9    | PC <= jump target
// I_EXEC 10 | immediate ALU operation
// JR 11     | PC <= A
// JAL 12    | PC <= jump target, $31 <= PC+4 (MULTICYCLE_JAL_EN only)
// I_WB 13   | write ALUOut to rt
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int TO_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_JR        = 4'd11,
    S_JAL       = 4'd12,
    S_I_WB      = 4'd13
  } state_t;

  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;

  localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(MEM_WAIT_MAX);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_state;
  logic            to_hit;
  logic            dec_illegal;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, wait-counter and decode/timeout qualification.
  always_comb begin
    state_d     = S_FETCH;
    cnt_d       = '0;
    dec_illegal = 1'b0;
    mem_state   = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                  (state_q == S_MEM_WRITE);
    // A ready on the limit cycle takes priority over the timeout.
    to_hit      = mem_state && (cnt_q == WAIT_LIMIT) && !mem_ready_i;

    unique case (state_q)
      S_FETCH:     state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode_i)
          6'b000000: begin
            unique case (funct_i)
              6'b001000: state_d = S_JR;
              6'b100000, 6'b100010, 6'b100101, 6'b000000,
              6'b000010, 6'b100100, 6'b100111: state_d = S_R_EXEC;
              default: dec_illegal = 1'b1;
            endcase
          end
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000100, 6'b000101: state_d = S_BRANCH;
          6'b001000, 6'b001111, 6'b001101, 6'b001100: state_d = S_I_EXEC;
          6'b000010: state_d = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          6'b000011: state_d = S_JAL;
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode_i == 6'b100011) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase

    if (to_hit) begin
      state_d = S_FETCH;
    end else if (mem_state && !mem_ready_i) begin
      // Still waiting in the same memory state.
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Moore-style strobe decode; timeout and reset force every strobe low.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    alu_op_o        = ALU_ADD;
    illegal_o       = 1'b0;
    timeout_o       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        illegal_o   = dec_illegal;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_RTYPE;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
        branch_ne_o     = opcode_i[0];
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        unique case (opcode_i)
          6'b001000: alu_op_o = ALU_ADDI;
          6'b001111: alu_op_o = ALU_LUI;
          6'b001101: alu_op_o = ALU_ORI;
          6'b001100: alu_op_o = ALU_ANDI;
          default:   alu_op_o = ALU_ADD;
        endcase
      end
      S_JR: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b11;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
        reg_write_o = 1'b1;
        reg_dst_o   = 2'b10;
      end
`endif
      S_I_WB: begin
        reg_write_o = 1'b1;
      end
      default: ;
    endcase

    if (to_hit || !reset) begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      illegal_o       = 1'b0;
      timeout_o       = to_hit && reset;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, branch_ne_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, ir_write_o, mem_to_reg_o, reg_write_o;
  logic [1:0] reg_dst_o, alu_src_b_o, pc_source_o;
  logic       alu_src_a_o;
  logic [2:0] alu_op_o;
  logic       illegal_o, timeout_o;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  multicycle_control #(.MEM_WAIT_MAX(15), .TO_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_i        (opcode_i),
    .funct_i         (funct_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .branch_ne_o     (branch_ne_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .reg_dst_o       (reg_dst_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .pc_source_o     (pc_source_o),
    .alu_op_o        (alu_op_o),
    .illegal_o       (illegal_o),
    .timeout_o       (timeout_o),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are looked at 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Set inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    mem_ready_i = rdy;
    opcode_i    = op;
    funct_i     = fn;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 6'b0, 6'b0);
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if ({mem_read_o, ir_write_o, pc_write_o, reg_write_o, mem_write_o} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=00000", {mem_read_o, ir_write_o, pc_write_o, reg_write_o, mem_write_o}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_lw();
    int seq[8];
    int exp_seq[8] = '{0, 0, 0, 1, 2, 3, 4, 0};
    logic [7:0] rw, m2r;
    for (int i = 0; i < 8; i++) begin
      drive((i >= 2), 6'b100011, 6'b0);
      seq[i] = state_o;
      rw[i]  = reg_write_o;
      m2r[i] = mem_to_reg_o;
      if (i == 2) begin
        checks++; if ({ir_write_o, pc_write_o, pc_source_o} !== 4'b1100) begin
          errors++; $display("FAIL lw_fetch_load got=%b exp=1100", {ir_write_o, pc_write_o, pc_source_o}); end
      end
      if (i == 4 || i == 7) begin
        checks++; if (alu_op_o !== 3'b101) begin errors++; $display("FAIL lw_alu_add cyc=%0d got=%b exp=101", i, alu_op_o); end
      end
      if (i == 5) begin
        checks++; if ({mem_read_o, i_or_d_o} !== 2'b11) begin errors++; $display("FAIL lw_mem_read got=%b exp=11", {mem_read_o, i_or_d_o}); end
      end
      if (i < 7) tick();
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL lw_seq cyc=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
    end
    checks++; if (rw !== 8'b0100_0000 || m2r !== 8'b0100_0000) begin
      errors++; $display("FAIL lw_wb got rw=%b m2r=%b exp=01000000", rw, m2r); end
  endtask

  task automatic test_alu_ops();
    // ADD: fetch, decode, R_EXEC, R_WB, back to fetch after 4 cycles.
    drive(1'b1, 6'b000000, 6'b100000); tick();
    drive(1'b1, 6'b000000, 6'b100000); tick();
    checks++; if ({state_o, alu_op_o, alu_src_a_o, alu_src_b_o} !== {4'd6, 3'b111, 1'b1, 2'b00}) begin
      errors++; $display("FAIL add_exec got st=%0d op=%b exp st=6 op=111", state_o, alu_op_o); end
    tick();
    checks++; if ({state_o, reg_write_o, reg_dst_o} !== {4'd7, 1'b1, 2'b01}) begin
      errors++; $display("FAIL add_wb got st=%0d rw=%b dst=%b exp 7/1/01", state_o, reg_write_o, reg_dst_o); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL add_len got=%0d exp=0", state_o); end
    // ORI
    drive(1'b1, 6'b001101, 6'b0); tick(); tick();
    checks++; if ({state_o, alu_op_o, alu_src_b_o} !== {4'd10, 3'b010, 2'b10}) begin
      errors++; $display("FAIL ori_exec got st=%0d op=%b exp st=10 op=010", state_o, alu_op_o); end
    tick();
    checks++; if ({state_o, reg_write_o, reg_dst_o} !== {4'd13, 1'b1, 2'b00}) begin
      errors++; $display("FAIL ori_wb got st=%0d rw=%b dst=%b exp 13/1/00", state_o, reg_write_o, reg_dst_o); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL ori_len got=%0d exp=0", state_o); end
  endtask

  task automatic test_branch();
    logic [5:0] ops[2] = '{6'b000101, 6'b000100};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, ops[k], 6'b0); tick(); tick();
      checks++; if ({state_o, pc_write_cond_o, branch_ne_o, alu_op_o, pc_source_o} !==
                    {4'd8, 1'b1, ~logic'(k), 3'b110, 2'b01}) begin
        errors++; $display("FAIL branch_%0d got st=%0d pwc=%b ne=%b op=%b exp ne=%b", k, state_o,
                           pc_write_cond_o, branch_ne_o, alu_op_o, ~logic'(k)); end
      tick();
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 6'b000010, 6'b0);
      if (timeout_o !== 1'b0) early++;
      tick();
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early got=%0d exp=0", early); end
    drive(1'b0, 6'b000010, 6'b0);
    checks++; if ({timeout_o, ir_write_o, mem_read_o} !== 3'b100) begin
      errors++; $display("FAIL to_pulse got=%b exp=100", {timeout_o, ir_write_o, mem_read_o}); end
    tick();
    checks++; if ({state_o, timeout_o, mem_read_o} !== {4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL to_after got st=%0d to=%b exp st=0 to=0", state_o, timeout_o); end
    // Ready arriving on the limit cycle wins.
    for (int i = 0; i < 15; i++) begin drive(1'b0, 6'b000010, 6'b0); tick(); end
    drive(1'b1, 6'b000010, 6'b0);
    checks++; if ({timeout_o, ir_write_o} !== 2'b01) begin
      errors++; $display("FAIL to_ready_wins got=%b exp=01", {timeout_o, ir_write_o}); end
    tick();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL to_ready_next got=%0d exp=1", state_o); end
    tick();
    checks++; if ({state_o, pc_write_o, pc_source_o} !== {4'd9, 1'b1, 2'b10}) begin
      errors++; $display("FAIL jump got st=%0d pw=%b src=%b exp 9/1/10", state_o, pc_write_o, pc_source_o); end
    tick();
  endtask

  task automatic test_illegal();
    logic [11:0] vec[3] = '{{6'b111111, 6'b0}, {6'b000000, 6'b101010}, {6'b000011, 6'b0}};
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, vec[k][11:6], vec[k][5:0]); tick();
`ifdef MULTICYCLE_JAL_EN
      if (k == 2) begin
        tick();
        checks++; if ({state_o, reg_write_o, reg_dst_o} !== {4'd12, 1'b1, 2'b10}) begin
          errors++; $display("FAIL jal got st=%0d rw=%b dst=%b exp 12/1/10", state_o, reg_write_o, reg_dst_o); end
        tick();
        continue;
      end
`endif
      checks++; if ({illegal_o, reg_write_o, mem_write_o} !== 3'b100) begin
        errors++; $display("FAIL illegal_%0d got=%b exp=100", k, {illegal_o, reg_write_o, mem_write_o}); end
      tick();
      checks++; if ({state_o, illegal_o} !== {4'd0, 1'b0}) begin
        errors++; $display("FAIL illegal_ret_%0d got st=%0d ill=%b exp 0/0", k, state_o, illegal_o); end
    end
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 6'b101011, 6'b0); tick(); tick(); tick();
    drive(1'b0, 6'b101011, 6'b0);
    checks++; if ({state_o, mem_write_o} !== {4'd5, 1'b1}) begin
      errors++; $display("FAIL sw_write got st=%0d mw=%b exp 5/1", state_o, mem_write_o); end
    reset = 1'b0;
    #1;
    checks++; if ({state_o, mem_write_o, mem_read_o} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got st=%0d mw=%b mr=%b exp 0/0/0", state_o, mem_write_o, mem_read_o); end
    tick();
    checks++; if ({mem_write_o, mem_read_o, pc_write_o, reg_write_o} !== 4'b0) begin
      errors++; $display("FAIL reset_hold got=%b exp=0000", {mem_write_o, mem_read_o, pc_write_o, reg_write_o}); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({state_o, mem_read_o} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL post_reset_fetch got st=%0d mr=%b exp 0/1", state_o, mem_read_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_alu_ops();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
